// File: rtl/mul_rr_arbiter.sv
// rtl/mul_rr_arbiter.sv - round-robin front end sharing one pipelined multiplier
//
// Purpose: accepts at most one operand pair per cycle from NREQ requesters in
// round-robin order. It registers the pair onto the multiplier inputs and
// carries the requester ID through a tag pipeline that matches the multiplier
// latency. It then returns the product tagged with that ID.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   en         issue enable (0 blocks new grants, in-flight ops drain)
//   req_valid  per-requester request valid                      [NREQ]
//   req_ready  per-requester grant, one-hot or zero, comb       [NREQ]
//   req_a      packed operand A, requester i at [i*W +: W]      [NREQ*W]
//   req_b      packed operand B, same packing                   [NREQ*W]
//   mul_a      registered operand A to multiplier               [W]
//   mul_b      registered operand B to multiplier               [W]
//   mul_out    multiplier product                               [2W]
//   rsp_valid  one-cycle response pulse per op
//   rsp_id     requester index of the response                  [IDW]
//   rsp_data   product                                          [2W]
//   idle       1 when no op is in flight (issue register included)
module mul_rr_arbiter #(
  parameter int W       = 4,
  parameter int NREQ    = 4,
  parameter int MUL_LAT = 2,
  parameter int IDW     = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [NREQ-1:0]   req_valid,
  output logic [NREQ-1:0]   req_ready,
  input  logic [NREQ*W-1:0] req_a,
  input  logic [NREQ*W-1:0] req_b,
  output logic [W-1:0]      mul_a,
  output logic [W-1:0]      mul_b,
  input  logic [2*W-1:0]    mul_out,
  output logic              rsp_valid,
  output logic [IDW-1:0]    rsp_id,
  output logic [2*W-1:0]    rsp_data,
  output logic              idle
);

  // ptr holds the last granted index; the search starts one past it.
  logic [IDW-1:0] ptr;
  logic [IDW-1:0] grant_idx;
  logic           grant_any;

  // Stage 0 is the issue register (aligned with mul_a/mul_b). Stage MUL_LAT
  // is valid in the cycle where mul_out carries that op's product.
  logic [MUL_LAT:0]           tag_v;
  logic [MUL_LAT:0][IDW-1:0]  tag_id;

  always_comb begin : arb
    int idx;
    idx       = 0;
    grant_any = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NREQ; k++) begin
      idx = (int'(ptr) + k) % NREQ;
      if (en && !grant_any && req_valid[idx]) begin
        grant_any = 1'b1;
        grant_idx = IDW'(idx);
      end
    end
  end

  assign req_ready = grant_any ? (NREQ'(1) << grant_idx) : '0;
  assign idle      = ~|tag_v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr       <= IDW'(NREQ - 1);
      mul_a     <= '0;
      mul_b     <= '0;
      tag_v     <= '0;
      tag_id    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_data  <= '0;
    end else begin
      // A grant is only ever given to a valid requester, so a grant is a transfer.
      if (grant_any) begin
        mul_a <= req_a[grant_idx*W +: W];
        mul_b <= req_b[grant_idx*W +: W];
        ptr   <= grant_idx;
      end

      // The multiplier never stalls, so the tags shift every cycle.
      tag_v  <= {tag_v[MUL_LAT-1:0], grant_any};
      tag_id <= {tag_id[MUL_LAT-1:0], grant_idx};

      rsp_valid <= tag_v[MUL_LAT];
      if (tag_v[MUL_LAT]) begin
        rsp_id   <= tag_id[MUL_LAT];
        rsp_data <= mul_out;
      end
    end
  end

endmodule

// File: doc/mul_rr_arbiter.md
Name: mul_rr_arbiter

Overview:
- Shares one fixed-latency, fully pipelined unsigned multiplier (N=4 operand, 2N result, 2-cycle input-to-output latency, no valid/enable) between NREQ requesters.
- Round-robin arbitration accepts at most one operand pair per cycle, registers it onto the multiplier inputs and tracks the requester ID through a shift pipeline.
- Captures the product and returns it with the requester ID.
- Sits between the requesting engines and the multiplier instance.

Parameters:
- W, 4, operand width; must equal the multiplier's N.
- NREQ, 4, number of requesters (2..8).
- MUL_LAT, 2, clock edges from mul_a/mul_b change to the matching mul_out.
- IDW, 2, ID width = clog2(NREQ).

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- en  in  1  issue enable; 0 blocks new grants, in-flight ops still complete
- req_valid  in  NREQ  per-requester request valid
- req_ready  out  NREQ  per-requester grant, one-hot or zero, combinational
- req_a  in  NREQ*W  operand A, requester i at [i*W +: W]
- req_b  in  NREQ*W  operand B, same packing
- mul_a  out  W  registered operand A to multiplier
- mul_b  out  W  registered operand B to multiplier
- mul_out  in  2W  multiplier product
- rsp_valid  out  1  registered response valid, one-cycle pulse per op
- rsp_id  out  IDW  requester index of response
- rsp_data  out  2W  product
- idle  out  1  1 when no op in flight, including the issue register

Behaviour:
- Reset (async, rst=1): ptr=NREQ-1, issue register invalid, tag pipeline cleared. Outputs: mul_a=0, mul_b=0, rsp_valid=0, rsp_id=0, rsp_data=0, idle=1.
- Reset asserted mid-operation drops all in-flight ops; no response is ever produced for them.
- Arbitration (combinational): if en=1 and any req_valid, grant the first valid index searching ptr+1, ptr+2, … modulo NREQ.
  - req_ready has exactly that bit set; otherwise req_ready=0.
  - req_ready never depends on req_valid of a non-granted index being 0.
- Handshake: transfer occurs on the edge where req_valid[i] & req_ready[i].
  - At that edge: mul_a/mul_b <= req_a/req_b slice i; ptr <= i; issue tag {valid=1, id=i} enters stage 0.
  - With no transfer: stage 0 valid <= 0; mul_a/mul_b hold their last value; ptr holds.
- Tag pipeline: MUL_LAT+1 stages, shifting every cycle unconditionally. There is no backpressure, because the multiplier is always running.
- Response: at the edge where the last tag stage is valid, rsp_valid<=1, rsp_id<=tag id, rsp_data<=mul_out. Otherwise rsp_valid<=0 and rsp_id/rsp_data hold.
- Latency: accept at edge k -> rsp_valid high in the cycle after edge k+MUL_LAT+1 (k+3 with defaults).
- Throughput: one op per cycle sustained; back-to-back responses in accept order.
- Fairness: a continuously valid requester is granted within NREQ accepts. A single lone requester is granted every cycle.
- Width rule: the product is unsigned, 2W bits, with no truncation; max (2^W-1)^2 = 225 for W=4.
- en=0: no grants; in-flight ops drain normally; ptr unchanged.
- idle = no valid tag in any stage.
- Requester i's req_a/req_b are sampled only at its own handshake edge and may change freely afterwards.

Test Plan:
- Reset: rst pulsed asynchronously between clock edges -> all outputs 0, idle=1 immediately. A request issued 2 cycles after the accept, then rst, yields no rsp_valid.
- Single op: req0 a=3,b=5 held one cycle with en=1 -> req_ready=0001 that cycle; rsp_valid pulses 3 edges later with id=0, data=15; idle returns to 1.
- Round robin: all four valid continuously, a=i+1, b=15 -> grant order 0,1,2,3,0,…. Responses are back-to-back: (0,15), (1,30), (2,45), (3,60), with no gaps.
- Max values: req2 a=15,b=15 -> rsp id=2 data=225. Then a=0,b=9 -> data=0.
- Enable gating: req1 valid with en=0 for 5 cycles -> req_ready=0, no responses. On en=1, granted at the first edge and the response follows 3 edges later. An in-flight op issued before en fell still completes.
- Fairness skip: req0 and req3 valid, ptr=0 -> grant 3, then 0, then 3. An idle requester 1 joining is granted before 3 when ptr=0.
